// File: rtl/blctrl_scheduler.sv
// Frame scheduler for up to eight I2C brushless controllers: once per refresh
// frame it writes each enabled, non-faulted motor's speed byte to its address.
module blctrl_scheduler #(
    parameter int         REFRESH_CYCLES = 32000,
    parameter logic [6:0] BASE_ADDR      = 7'h29,
    parameter int         MAX_NACK       = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        masterEnable,
    input  logic [7:0]  motorEnable,
    input  logic [63:0] targetSpeedFlat,
    input  logic [7:0]  fault_clear,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [6:0]  cmd_addr,
    output logic [7:0]  cmd_data,
    input  logic        txn_done,
    input  logic        txn_nack,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  fault,
    output logic        overrun
);

    localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, ISSUE, WAIT_DONE} state_t;

    state_t          state;
    logic [CW-1:0]   ref_cnt;
    logic            tick;
    logic [2:0]      idx;
    logic [7:0]      en_snap;
    logic [7:0][7:0] spd_snap;
    logic [7:0]      faulted;

    assign tick  = (ref_cnt == CW'(REFRESH_CYCLES - 1));
    assign busy  = (state != IDLE);
    assign fault = faulted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ref_cnt <= '0;
        else if (!masterEnable || tick)
            ref_cnt <= '0;
        else
            ref_cnt <= ref_cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 3'd0;
            en_snap    <= 8'd0;
            spd_snap   <= '0;
            cmd_valid  <= 1'b0;
            cmd_addr   <= 7'd0;
            cmd_data   <= 8'd0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (tick && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (tick && masterEnable) begin
                        en_snap  <= motorEnable & ~faulted;
                        spd_snap <= targetSpeedFlat;
                        idx      <= 3'd0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (!masterEnable) begin
                        state <= IDLE;
                    end else if (en_snap[idx]) begin
                        cmd_valid <= 1'b1;
                        cmd_addr  <= BASE_ADDR + {4'b0, idx};
                        cmd_data  <= spd_snap[idx];
                        state     <= ISSUE;
                    end else if (idx == 3'd7) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                ISSUE: begin
                    // An accepted request must be tracked to completion even if
                    // the enable drops in the same cycle.
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= WAIT_DONE;
                    end else if (!masterEnable) begin
                        cmd_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                WAIT_DONE: begin
                    if (txn_done) begin
                        if (!masterEnable) begin
                            state <= IDLE;
                        end else if (idx == 3'd7) begin
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= SCAN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-motor saturating NACK counter with sticky fault; clear beats set.
    for (genvar n = 0; n < 8; n++) begin : g_lane
        logic [2:0] cnt;
        logic [2:0] inc;
        logic       upd;

        assign inc = (cnt == 3'd7) ? 3'd7 : cnt + 3'd1;
        assign upd = (state == WAIT_DONE) && txn_done && (idx == 3'(n));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt        <= 3'd0;
                faulted[n] <= 1'b0;
            end else if (fault_clear[n]) begin
                cnt        <= 3'd0;
                faulted[n] <= 1'b0;
            end else if (upd) begin
                if (txn_nack) begin
                    cnt <= inc;
                    if (inc >= 3'(MAX_NACK))
                        faulted[n] <= 1'b1;
                end else begin
                    cnt <= 3'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_blctrl_scheduler.sv
// Directed bench for blctrl_scheduler: frame vectors from a table plus
// hand sequences for fault clear, overrun, enable drop and mid-transaction reset.
module tb_blctrl_scheduler;

    localparam int RC = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        masterEnable = 1'b0;
    logic [7:0]  motorEnable = 8'd0;
    logic [63:0] targetSpeedFlat = 64'd0;
    logic [7:0]  fault_clear = 8'd0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic [6:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic        txn_done;
    logic        txn_nack;
    logic        busy;
    logic        frame_done;
    logic [7:0]  fault;
    logic        overrun;

    logic rsp_done = 1'b0, rsp_nack = 1'b0, spur_done = 1'b0;
    assign txn_done = rsp_done | spur_done;
    assign txn_nack = rsp_nack | spur_done;

    always #5 clk = ~clk;

    blctrl_scheduler #(.REFRESH_CYCLES(RC), .BASE_ADDR(7'h29), .MAX_NACK(3)) dut (
        .clk(clk), .rst_n(rst_n), .masterEnable(masterEnable),
        .motorEnable(motorEnable), .targetSpeedFlat(targetSpeedFlat),
        .fault_clear(fault_clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .txn_done(txn_done),
        .txn_nack(txn_nack), .busy(busy), .frame_done(frame_done),
        .fault(fault), .overrun(overrun)
    );

    int         checks = 0;
    int         failures = 0;
    int         delay = 5;
    logic [7:0] nack_mask = 8'd0;
    logic [6:0] wa[$];
    logic [7:0] wd[$];

    typedef struct {
        logic [7:0] men;
        logic [7:0] spd_base;
        logic [7:0] spd_step;
        logic [7:0] nack;
        logic [7:0] exp_wr;
        logic [7:0] exp_fault;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_frame(input int budget, input string nm);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1;
        end
        chk({nm, " frame_done"}, 64'(seen), 64'd1);
    endtask

    task automatic wait_valid(input int budget, input string nm);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (cmd_valid) seen = 1;
        end
        chk({nm, " cmd_valid seen"}, 64'(seen), 64'd1);
    endtask

    // Responder: accepts when ready, pulses txn_done 'delay' cycles after accept.
    initial begin : responder
        int         dcnt;
        bit         pend;
        bit         pn;
        logic [6:0] off;
        dcnt = 0; pend = 0; pn = 0;
        forever begin
            @(negedge clk);
            rsp_done = 1'b0;
            rsp_nack = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else if (pend) begin
                dcnt--;
                if (dcnt <= 0) begin
                    rsp_done = 1'b1;
                    rsp_nack = pn;
                    pend = 0;
                end
            end else if (cmd_valid && cmd_ready) begin
                wa.push_back(cmd_addr);
                wd.push_back(cmd_data);
                off  = cmd_addr - 7'h29;
                pn   = nack_mask[off[2:0]];
                dcnt = delay;
                pend = 1;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : main
        int j;
        int cnt_v;
        int cnt_f;
        bit seen;
        logic [7:0] e;

        tbl[0] = '{8'hFF, 8'h80, 8'h00, 8'h00, 8'hFF, 8'h00};
        tbl[1] = '{8'h05, 8'h85, 8'h00, 8'h00, 8'h05, 8'h00};
        tbl[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[3] = '{8'hA0, 8'h10, 8'h01, 8'h00, 8'hA0, 8'h00};
        tbl[4] = '{8'h04, 8'h07, 8'h00, 8'h04, 8'h04, 8'h00};
        tbl[5] = '{8'h04, 8'h07, 8'h00, 8'h04, 8'h04, 8'h00};
        tbl[6] = '{8'h04, 8'h07, 8'h00, 8'h04, 8'h04, 8'h04};
        tbl[7] = '{8'h0C, 8'h07, 8'h00, 8'h04, 8'h08, 8'h04};

        repeat (3) @(negedge clk);
        chk("rst cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst cmd_addr", 64'(cmd_addr), 64'd0);
        chk("rst cmd_data", 64'(cmd_data), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst frame_done", 64'(frame_done), 64'd0);
        chk("rst fault", 64'(fault), 64'd0);
        chk("rst overrun", 64'(overrun), 64'd0);
        rst_n = 1'b1;
        masterEnable = 1'b1;
        wait_frame(300, "sync");

        for (int i = 0; i < 8; i++) begin
            motorEnable = tbl[i].men;
            nack_mask   = tbl[i].nack;
            for (int n = 0; n < 8; n++)
                targetSpeedFlat[8*n +: 8] = 8'(tbl[i].spd_base + tbl[i].spd_step * n);
            wa.delete();
            wd.delete();
            wait_frame(300, $sformatf("vec%0d", i));
            j = 0;
            for (int n = 0; n < 8; n++) begin
                if (tbl[i].exp_wr[n]) begin
                    e = 8'(tbl[i].spd_base + tbl[i].spd_step * n);
                    if (j < wa.size()) begin
                        chk($sformatf("vec%0d addr%0d", i, j), 64'(wa[j]), 64'(7'h29 + n));
                        chk($sformatf("vec%0d data%0d", i, j), 64'(wd[j]), 64'(e));
                    end
                    j++;
                end
            end
            chk($sformatf("vec%0d write count", i), 64'(wa.size()), 64'(j));
            chk($sformatf("vec%0d fault", i), 64'(fault), 64'(tbl[i].exp_fault));
            chk($sformatf("vec%0d overrun", i), 64'(overrun), 64'd0);
            chk($sformatf("vec%0d busy", i), 64'(busy), 64'd0);
        end

        // fault_clear on motor 2 lets it back into the next frame
        motorEnable = 8'h04;
        nack_mask   = 8'h00;
        fault_clear = 8'h04;
        @(negedge clk);
        fault_clear = 8'h00;
        chk("clr fault", 64'(fault), 64'd0);
        wa.delete();
        wd.delete();
        wait_frame(300, "clr");
        chk("clr write count", 64'(wa.size()), 64'd1);
        if (wa.size() > 0) chk("clr addr", 64'(wa[0]), 64'h2B);
        chk("clr fault after", 64'(fault), 64'd0);

        // txn_done with NACK while idle must not touch any fault
        for (int k = 0; k < 4; k++) begin
            spur_done = 1'b1;
            @(negedge clk);
            spur_done = 1'b0;
            @(negedge clk);
        end
        chk("idle done fault", 64'(fault), 64'd0);
        chk("idle done busy", 64'(busy), 64'd0);

        // slow responder forces overrun; frame still completes
        motorEnable = 8'hFF;
        targetSpeedFlat = {8{8'h80}};
        delay = 120;
        wa.delete();
        wd.delete();
        wait_frame(2500, "ovr");
        chk("ovr write count", 64'(wa.size()), 64'd8);
        if (wa.size() == 8) chk("ovr last addr", 64'(wa[7]), 64'h30);
        chk("ovr overrun", 64'(overrun), 64'd1);
        delay = 5;
        seen = 0;
        cnt_v = 0;
        for (int k = 0; k < 150 && !seen; k++) begin
            @(negedge clk);
            cnt_v++;
            if (cmd_valid) seen = 1;
        end
        chk("ovr next frame start", 64'(seen && cnt_v <= RC + 2), 64'd1);
        wait_frame(300, "ovr resync");

        // enable dropped while a request is stalled
        cmd_ready = 1'b0;
        wait_valid(200, "drop");
        masterEnable = 1'b0;
        @(negedge clk);
        chk("drop cmd_valid", 64'(cmd_valid), 64'd0);
        chk("drop busy", 64'(busy), 64'd0);
        cnt_v = 0;
        cnt_f = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (cmd_valid) cnt_v++;
            if (frame_done) cnt_f++;
        end
        chk("drop no valid", 64'(cnt_v), 64'd0);
        chk("drop no frame_done", 64'(cnt_f), 64'd0);
        cmd_ready = 1'b1;
        masterEnable = 1'b1;
        wait_frame(300, "reenable");

        // reset during WAIT_DONE
        wait_valid(200, "rst mid");
        repeat (2) @(negedge clk);
        chk("rst mid busy before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst mid cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst mid busy", 64'(busy), 64'd0);
        chk("rst mid overrun", 64'(overrun), 64'd0);
        chk("rst mid cmd_addr", 64'(cmd_addr), 64'd0);
        chk("rst mid cmd_data", 64'(cmd_data), 64'd0);
        chk("rst mid fault", 64'(fault), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt_v = 0;
        for (int k = 0; k < RC; k++) begin
            @(negedge clk);
            if (cmd_valid) cnt_v++;
        end
        chk("post rst quiet", 64'(cnt_v), 64'd0);
        wait_valid(10, "post rst");
        chk("post rst addr", 64'(cmd_addr), 64'h29);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
